// File: rtl/morse_decoder_if.sv
// -----------------------------------------------------------------------------
// morse_decoder_if
// Signal bundle between the Morse decoder and the key / display logic.
//   key_in     : raw push-button level into the decoder (asynchronous, bouncy)
//   key_db     : debounced key level, for LED echo
//   char_valid : one-cycle character strobe
//   char_data  : ASCII character, valid while char_valid is high
//   char_error : high with char_valid when char_data is '?'
//   busy       : decoder is timing a mark, gap or word gap
// master = decoder side, slave = key source / display consumer side.
// -----------------------------------------------------------------------------
interface morse_decoder_if;
    logic       key_in;
    logic       key_db;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_error;
    logic       busy;

    modport master (
        input  key_in,
        output key_db, char_valid, char_data, char_error, busy
    );

    modport slave (
        output key_in,
        input  key_db, char_valid, char_data, char_error, busy
    );
endinterface

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Decodes a hand-keyed Morse signal from a push-button into ASCII characters.
// The key is synchronised and debounced, marks and gaps are timed in units of
// UNIT_CYCLES, marks are classified as dot/dash and each completed character
// is looked up in the ITU table and emitted as a one-cycle strobe. A space is
// emitted after a word gap that follows a character.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : morse_decoder_if.master (key_in in; key_db, char_valid, char_data,
//         char_error, busy out)
// -----------------------------------------------------------------------------
module morse_decoder #(
    parameter int UNIT_CYCLES     = 2097152,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    morse_decoder_if.master bus
);

    localparam int DUR_W = $clog2(5 * UNIT_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DUR_W-1:0] DUR_CHAR = DUR_W'(2 * UNIT_CYCLES);
    localparam logic [DUR_W-1:0] DUR_WORD = DUR_W'(5 * UNIT_CYCLES);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;

    logic             key_s1, key_s2;
    logic             key_db;
    logic [DB_W-1:0]  db_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [5:0]       sym_bits;
    logic [2:0]       sym_len;
    state_t           state;
    logic             char_valid, char_error, busy;
    logic [7:0]       char_data;
    logic [7:0]       looked_up;

    // ITU lookup; symbols are oldest-first from the MSB of the used bits,
    // 1 = dash, 0 = dot.
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [5:0] bits);
        logic [7:0] ch;
        // NOTE: ch gets a default before the case so every path assigns it;
        // a missing assignment in combinational logic would infer a latch.
        ch = "?";
        case (len)
            3'd1: ch = bits[0] ? "T" : "E";
            3'd2: case (bits[1:0])
                2'b00: ch = "I";  2'b01: ch = "A";
                2'b10: ch = "N";  2'b11: ch = "M";
                default: ch = "?";
            endcase
            3'd3: case (bits[2:0])
                3'b000: ch = "S";  3'b001: ch = "U";  3'b010: ch = "R";  3'b011: ch = "W";
                3'b100: ch = "D";  3'b101: ch = "K";  3'b110: ch = "G";  3'b111: ch = "O";
                default: ch = "?";
            endcase
            3'd4: case (bits[3:0])
                4'b0000: ch = "H";  4'b0001: ch = "V";  4'b0010: ch = "F";  4'b0100: ch = "L";
                4'b0110: ch = "P";  4'b0111: ch = "J";  4'b1000: ch = "B";  4'b1001: ch = "X";
                4'b1010: ch = "C";  4'b1011: ch = "Y";  4'b1100: ch = "Z";  4'b1101: ch = "Q";
                default: ch = "?";
            endcase
            3'd5: case (bits[4:0])
                5'b01111: ch = "1";  5'b00111: ch = "2";  5'b00011: ch = "3";
                5'b00001: ch = "4";  5'b00000: ch = "5";  5'b10000: ch = "6";
                5'b11000: ch = "7";  5'b11100: ch = "8";  5'b11110: ch = "9";
                5'b11111: ch = "0";
                default:  ch = "?";
            endcase
            default: ch = "?";  // empty buffer or 6+ symbols
        endcase
        return ch;
    endfunction

    // The debounced level flips in the cycle the counter completes; rise/fall
    // are therefore known one cycle before key_db itself changes, which lets
    // dur_cnt still hold the full length of the level that is ending.
    logic db_flip, rise, fall;
    assign db_flip   = (key_s2 != key_db) && (db_cnt == DB_LAST);
    assign rise      = db_flip &  key_s2;
    assign fall      = db_flip & ~key_s2;
    assign looked_up = lookup(sym_len, sym_bits);

    // Input conditioning and level-duration timing.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1  <= 1'b0;
            key_s2  <= 1'b0;
            key_db  <= 1'b0;
            db_cnt  <= '0;
            dur_cnt <= '0;
        end else begin
            key_s1 <= bus.key_in;
            key_s2 <= key_s1;

            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (db_flip)
                dur_cnt <= DUR_ONE;
            else if (dur_cnt != DUR_WORD)
                dur_cnt <= dur_cnt + 1'b1;
        end
    end

    // Symbol collection and character/space emission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            // NOTE: the symbol buffer is reset explicitly so a reset mid-character
            // cannot leak stale symbols into the next decoded character.
            sym_bits   <= '0;
            sym_len    <= '0;
            char_valid <= 1'b0;
            char_data  <= 8'h00;
            char_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            char_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MARK;
                        busy  <= 1'b1;
                    end
                end

                MARK: begin
                    if (fall) begin
                        sym_bits <= {sym_bits[4:0], (dur_cnt >= DUR_CHAR)};
                        if (sym_len != 3'd7)
                            sym_len <= sym_len + 3'd1;
                        state <= GAP;
                    end
                end

                GAP: begin
                    // A rise wins over a threshold hit in the same cycle.
                    if (rise) begin
                        state <= MARK;
                    end else if (dur_cnt >= DUR_CHAR) begin
                        char_valid <= 1'b1;
                        char_data  <= looked_up;
                        char_error <= (looked_up == "?");
                        sym_bits   <= '0;
                        sym_len    <= '0;
                        state      <= WORD;
                    end
                end

                WORD: begin
                    if (rise) begin
                        state <= MARK;
                    end else if (dur_cnt >= DUR_WORD) begin
                        char_valid <= 1'b1;
                        char_data  <= 8'h20;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_db     = key_db;
    assign bus.char_valid = char_valid;
    assign bus.char_data  = char_data;
    assign bus.char_error = char_error;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
// Self-checking bench for morse_decoder with UNIT_CYCLES=10, DEBOUNCE_CYCLES=3.
// Stimulus keys characters from an ITU dot/dash string table; the expected
// character (and any space) is queued as each character is keyed, and a
// monitor pops and compares on every char_valid strobe.
// -----------------------------------------------------------------------------
module tb_morse_decoder;

    localparam int UNIT = 10;
    localparam int DB   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_decoder_if mif ();

    morse_decoder #(
        .UNIT_CYCLES    (UNIT),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mif.master)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];   // {char_error, char_data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: ITU code for each character as a dot/dash string.
    function automatic string morse_of(input byte c);
        case (c)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            default: return "";
        endcase
    endfunction

    task automatic hold(input logic lvl, input int n);
        mif.key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Dots 4..16 cycles, dashes 24..40, intra-character gaps 4..16:
    // all well clear of the 20-cycle decision point.
    task automatic send_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            if (p[i] == "-") hold(1'b1, int'($urandom_range(24, 40)));
            else             hold(1'b1, int'($urandom_range(4, 16)));
            if (i != p.len() - 1) hold(1'b0, int'($urandom_range(4, 16)));
        end
    endtask

    task automatic expect_char(input byte c, input bit err);
        exp_q.push_back({err, c});
    endtask

    // Character gap 25..45 (no space) or 60..80 (space follows).
    task automatic send_char(input byte c, input bit space);
        send_pattern(morse_of(c));
        expect_char(c, 1'b0);
        if (space) begin
            expect_char(" ", 1'b0);
            hold(1'b0, int'($urandom_range(60, 80)));
        end else begin
            hold(1'b0, int'($urandom_range(25, 45)));
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (mif.char_error && !mif.char_valid) begin
                errors++;
                $display("FAIL error_without_strobe: got char_error=1, expected 0");
            end
            if (mif.char_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got 0x%0h err=%0b, expected none",
                             mif.char_data, mif.char_error);
                end else begin
                    e = exp_q.pop_front();
                    check("char", {23'd0, mif.char_error, mif.char_data}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        string alphabet;
        int    lat;
        bit    found;
        int    bad;
        byte   c;
        bit    sp;

        alphabet   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
        mif.key_in = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key_db",     mif.key_db,     0);
        check("rst_char_valid", mif.char_valid, 0);
        check("rst_char_data",  mif.char_data,  0);
        check("rst_char_error", mif.char_error, 0);
        check("rst_busy",       mif.busy,       0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 'E' with exact latency from key_db fall, then a space.
        expect_char("E", 1'b0);
        expect_char(" ", 1'b0);
        hold(1'b1, 10);
        mif.key_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!mif.key_db) found = 1'b1;
        end
        check("e_key_db_fall", found, 1);
        check("e_busy_in_gap", mif.busy, 1);
        lat = 0; found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (mif.char_valid) found = 1'b1;
        end
        check("e_latency", lat, 20);
        hold(1'b0, 60);
        check("idle_busy", mif.busy, 0);

        // Mark boundary: 19 cycles = dot, 20 cycles = dash.
        hold(1'b1, 19);
        expect_char("E", 1'b0); expect_char(" ", 1'b0);
        hold(1'b0, 70);
        hold(1'b1, 20);
        expect_char("T", 1'b0); expect_char(" ", 1'b0);
        hold(1'b0, 70);

        // S, press again before the word gap completes, then O and a space.
        hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 10);
        expect_char("S", 1'b0);
        hold(1'b0, 30);
        hold(1'b1, 30); hold(1'b0, 10); hold(1'b1, 30); hold(1'b0, 10); hold(1'b1, 30);
        expect_char("O", 1'b0); expect_char(" ", 1'b0);
        hold(1'b0, 70);

        // Bounce: 2-cycle pulses must never pass the debouncer.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            mif.key_in = ((i % 4) < 2);
            @(negedge clk);
            if (mif.key_db || mif.busy) bad++;
        end
        hold(1'b0, 10);
        check("bounce_db_or_busy_cycles", bad, 0);
        check("bounce_key_db", mif.key_db, 0);

        // Six dots -> '?' with error; .---- -> '1'.
        send_pattern("......");
        expect_char("?", 1'b1);
        hold(1'b0, 30);
        send_pattern(".----");
        expect_char("1", 1'b0); expect_char(" ", 1'b0);
        hold(1'b0, 70);

        // Reset mid-character after two dots.
        hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 10); hold(1'b0, 8);
        rst = 1'b1;
        #1;
        check("midrst_key_db",     mif.key_db,     0);
        check("midrst_char_valid", mif.char_valid, 0);
        check("midrst_char_data",  mif.char_data,  0);
        check("midrst_char_error", mif.char_error, 0);
        check("midrst_busy",       mif.busy,       0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 100);
        check("midrst_no_pending", exp_q.size(), 0);
        check("midrst_busy_after", mif.busy, 0);

        // Randomised characters and word gaps.
        for (int i = 0; i < 40; i++) begin
            c  = alphabet[int'($urandom_range(0, 35))];
            sp = (i == 39) || ($urandom_range(0, 3) == 0);
            send_char(c, sp);
        end

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (exp_q.size() == 0) found = 1'b1;
            else @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
